// File: rtl/pheap_issue_ctrl_if.sv
// Request, root-issue and status bundle between the requesters, pheap_issue_ctrl and the heap root level.
// The slave modport is the controller's view. The master modport is the environment's view.
interface pheap_issue_ctrl_if #(
  parameter int CAPACITY = 15,
  parameter int KV_W     = 32
);
  localparam int CNT_W = $clog2(CAPACITY + 1);

  logic            req0_valid;
  logic [1:0]      req0_op;
  logic [31:0]     req0_pri;
  logic [KV_W-1:0] req0_kv;
  logic            req0_ready;
  logic            req1_valid;
  logic [1:0]      req1_op;
  logic [31:0]     req1_pri;
  logic [KV_W-1:0] req1_kv;
  logic            req1_ready;
  logic            root_ready;
  logic [1:0]      root_op;
  logic [31:0]     root_pri;
  logic [KV_W-1:0] root_kv;
  logic [CNT_W-1:0] count;
  logic            full;
  logic            empty;
  logic            err_illegal;

  modport slave (
    input  req0_valid, req0_op, req0_pri, req0_kv,
    input  req1_valid, req1_op, req1_pri, req1_kv,
    input  root_ready,
    output req0_ready, req1_ready,
    output root_op, root_pri, root_kv,
    output count, full, empty, err_illegal
  );

  modport master (
    output req0_valid, req0_op, req0_pri, req0_kv,
    output req1_valid, req1_op, req1_pri, req1_kv,
    output root_ready,
    input  req0_ready, req1_ready,
    input  root_op, root_pri, root_kv,
    input  count, full, empty, err_illegal
  );
endinterface

// File: rtl/pheap_issue_ctrl.sv
// Two-requester issue controller for a pipelined heap. It issues one op every 3 cycles (IDLE -> ISSUE -> GAP).
// Define PHEAP_ISSUE_RR_EN for round-robin arbitration. Otherwise req0 has fixed priority over req1.
module pheap_issue_ctrl #(
  parameter int CAPACITY = 15,
  parameter int KV_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  pheap_issue_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(CAPACITY + 1);
  localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);
  localparam logic [1:0] OP_FREE = 2'd0;
  localparam logic [1:0] OP_LEQ  = 2'd1;
  localparam logic [1:0] OP_DEQ  = 2'd2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_GAP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [1:0]       root_op_q, root_op_d;
  logic [31:0]      root_pri_q, root_pri_d;
  logic [KV_W-1:0]  root_kv_q, root_kv_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             elig0_s, elig1_s, gnt0_s, gnt1_s, gnt_s, prefer1_s;
  logic [1:0]       gnt_op_s;
  logic [31:0]      gnt_pri_s;
  logic [KV_W-1:0]  gnt_kv_s;

  // Illegal codes are always eligible so that they are drained rather than left to block the port.
  function automatic logic op_eligible(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
    logic ok;
    case (op)
      OP_LEQ:  ok = (cnt < CAP_C);
      OP_DEQ:  ok = (cnt != ZERO_C);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

`ifdef PHEAP_ISSUE_RR_EN
  logic last_q;

  // last_q records the most recent winner. It resets to 1 so that req0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (gnt_s) begin
      last_q <= gnt1_s;
    end else begin
      last_q <= last_q;
    end
  end

  assign prefer1_s = ~last_q;
`else
  assign prefer1_s = 1'b0;
`endif

  // Grant logic. Ready is gated by rst so that it drops as soon as reset is asserted.
  always_comb begin
    elig0_s = bus.req0_valid & op_eligible(bus.req0_op, count_q);
    elig1_s = bus.req1_valid & op_eligible(bus.req1_op, count_q);
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    if (!rst && (state_q == S_IDLE) && bus.root_ready) begin
      if (elig0_s && elig1_s) begin
        gnt0_s = ~prefer1_s;
        gnt1_s = prefer1_s;
      end else begin
        gnt0_s = elig0_s;
        gnt1_s = elig1_s;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign gnt_s = gnt0_s | gnt1_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs. Root fields load only on a legal grant, so root_op is non-FREE only during ISSUE.
  always_comb begin
    gnt_op_s   = gnt1_s ? bus.req1_op  : bus.req0_op;
    gnt_pri_s  = gnt1_s ? bus.req1_pri : bus.req0_pri;
    gnt_kv_s   = gnt1_s ? bus.req1_kv  : bus.req0_kv;
    root_op_d  = OP_FREE;
    root_pri_d = root_pri_q;
    root_kv_d  = root_kv_q;
    count_d    = count_q;
    err_d      = 1'b0;
    if (gnt_s) begin
      case (gnt_op_s)
        OP_LEQ: begin
          root_op_d  = OP_LEQ;
          root_pri_d = gnt_pri_s;
          root_kv_d  = gnt_kv_s;
          count_d    = count_q + ONE_C;
        end
        OP_DEQ: begin
          root_op_d  = OP_DEQ;
          root_pri_d = gnt_pri_s;
          root_kv_d  = gnt_kv_s;
          count_d    = count_q - ONE_C;
        end
        default: err_d = 1'b1;
      endcase
    end else begin
      root_op_d = OP_FREE;
    end
  end

  // Registered root, occupancy and error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      root_op_q  <= OP_FREE;
      root_pri_q <= 32'd0;
      root_kv_q  <= '0;
      count_q    <= ZERO_C;
      err_q      <= 1'b0;
    end else begin
      root_op_q  <= root_op_d;
      root_pri_q <= root_pri_d;
      root_kv_q  <= root_kv_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  assign bus.req0_ready  = gnt0_s;
  assign bus.req1_ready  = gnt1_s;
  assign bus.root_op     = root_op_q;
  assign bus.root_pri    = root_pri_q;
  assign bus.root_kv     = root_kv_q;
  assign bus.count       = count_q;
  assign bus.full        = (count_q == CAP_C);
  assign bus.empty       = (count_q == ZERO_C);
  assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_pheap_issue_ctrl.sv
// Directed bench for pheap_issue_ctrl. A cycle model of the issue rules is checked against the DUT on every negedge.
// Hand-computed literal checks pin the model. Build with +define+PHEAP_ISSUE_RR_EN to cover the round-robin variant.
module tb_pheap_issue_ctrl;
  localparam int CAP  = 3;
  localparam int KV_W = 32;
`ifdef PHEAP_ISSUE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  pheap_issue_ctrl_if #(.CAPACITY(CAP), .KV_W(KV_W)) bus ();
  pheap_issue_ctrl #(.CAPACITY(CAP), .KV_W(KV_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Model state: occupancy, cycles left before a new grant is allowed, last winner, and expected outputs.
  int          m_count = 0;
  int          m_wait  = 0;
  int          m_last  = 1;
  int          m_g     = -1;
  logic [1:0]  m_op    = 2'd0;
  logic [31:0] m_pri   = 32'd0;
  logic [31:0] m_kv    = 32'd0;
  logic        m_err   = 1'b0;
  logic [1:0]  g_op;
  logic [31:0] g_pri, g_kv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit eligible(input logic [1:0] op);
    if (op == 2'd1) return m_count < CAP;
    else if (op == 2'd2) return m_count > 0;
    else return 1'b1;
  endfunction

  // Returns the index of the requester that must win this cycle, or -1 if none.
  function automatic int pick();
    bit a, b;
    if (m_wait != 0 || bus.root_ready !== 1'b1) return -1;
    a = bus.req0_valid && eligible(bus.req0_op);
    b = bus.req1_valid && eligible(bus.req1_op);
    if (a && b) return (RR && m_last == 0) ? 1 : 0;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  // Compare process. Inputs change only just after posedge, so the negedge sees them settled.
  always @(negedge clk) begin
    m_g   = pick();
    g_op  = (m_g == 1) ? bus.req1_op  : bus.req0_op;
    g_pri = (m_g == 1) ? bus.req1_pri : bus.req0_pri;
    g_kv  = (m_g == 1) ? bus.req1_kv  : bus.req0_kv;
    if (!rst) begin
      chk("ready0", bus.req0_ready, m_g == 0);
      chk("ready1", bus.req1_ready, m_g == 1);
      chk("root_op", bus.root_op, m_op);
      chk("root_pri", bus.root_pri, m_pri);
      chk("root_kv", bus.root_kv, m_kv);
      chk("count", bus.count, m_count);
      chk("full", bus.full, m_count == CAP);
      chk("empty", bus.empty, m_count == 0);
      chk("err_illegal", bus.err_illegal, m_err);
    end
  end

  // Model advance at each grant edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count <= 0; m_wait <= 0; m_last <= 1;
      m_op <= 2'd0; m_pri <= 32'd0; m_kv <= 32'd0; m_err <= 1'b0;
    end else if (m_g >= 0) begin
      m_wait <= 2;
      m_last <= m_g;
      m_err  <= !(g_op == 2'd1 || g_op == 2'd2);
      if (g_op == 2'd1 || g_op == 2'd2) begin
        m_op  <= g_op;
        m_pri <= g_pri;
        m_kv  <= g_kv;
        m_count <= m_count + ((g_op == 2'd1) ? 1 : -1);
      end else begin
        m_op <= 2'd0;
      end
    end else begin
      m_wait <= (m_wait > 0) ? m_wait - 1 : 0;
      m_op   <= 2'd0;
      m_err  <= 1'b0;
    end
  end

  task automatic drive(input int port, input logic v, input logic [1:0] op,
                       input logic [31:0] pri, input logic [31:0] kv);
    if (port == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_pri = pri; bus.req0_kv = kv;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_pri = pri; bus.req1_kv = kv;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts negedges until the requester sees ready, bounded. Returns 0 on timeout.
  task automatic wait_ready(input int port, output int n);
    bit got = 1'b0;
    n = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      got = (port == 0) ? bus.req0_ready : bus.req1_ready;
    end
    if (!got) begin
      chk("ready_timeout", 64'd0, 64'd1);
      n = 0;
    end
  endtask

  // Holds one request until it is granted, then drops it just after the grant edge.
  task automatic issue(input int port, input logic [1:0] op, input logic [31:0] pri, input logic [31:0] kv);
    int n;
    drive(port, 1'b1, op, pri, kv);
    wait_ready(port, n);
    step(1);
    drive(port, 1'b0, op, pri, kv);
  endtask

  task automatic watch_none(input int port, input int cycles, output bit seen);
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      seen |= (port == 0) ? bus.req0_ready : bus.req1_ready;
    end
  endtask

  initial begin
    int n;
    bit seen;
    logic [2:0] order;
    rst = 1'b1;
    bus.root_ready = 1'b1;
    drive(0, 1'b1, 2'd1, 32'd5, 32'hA5);
    drive(1, 1'b0, 2'd0, 32'd0, 32'd0);
    step(3);
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_root_op", bus.root_op, 2'd0);
    chk("rst_root_pri", bus.root_pri, 32'd0);
    chk("rst_root_kv", bus.root_kv, 32'd0);
    chk("rst_count", bus.count, 2'd0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_err", bus.err_illegal, 1'b0);
    rst = 1'b0;

    // First LEQ: grant in cycle 0, root in cycle 1, FREE in cycle 2.
    @(negedge clk);
    chk("t027_ready0", bus.req0_ready, 1'b1);
    step(1);
    drive(0, 1'b0, 2'd1, 32'd5, 32'hA5);
    @(negedge clk);
    chk("t027_root_op", bus.root_op, 2'd1);
    chk("t027_root_pri", bus.root_pri, 32'd5);
    chk("t027_count", bus.count, 2'd1);
    @(negedge clk);
    chk("t027_free", bus.root_op, 2'd0);
    step(1);

    // A DEQ on an empty heap stays pending until an LEQ gives it something to remove.
    issue(0, 2'd2, 32'd5, 32'h0);
    step(2);
    drive(1, 1'b1, 2'd2, 32'd0, 32'h11);
    watch_none(1, 6, seen);
    chk("t028_deq_blocked", seen, 1'b0);
    step(1);
    issue(0, 2'd1, 32'd7, 32'h77);
    wait_ready(1, n);
    chk("t028_deq_latency", n, 3);
    step(1);
    drive(1, 1'b0, 2'd2, 32'd0, 32'h11);
    step(3);
    chk("t028_count", bus.count, 2'd0);

    // Fill to capacity. A 4th LEQ stalls until a DEQ frees a slot.
    issue(0, 2'd1, 32'd1, 32'h101);
    issue(1, 2'd1, 32'd2, 32'h202);
    issue(0, 2'd1, 32'd3, 32'h303);
    step(3);
    chk("t029_full", bus.full, 1'b1);
    drive(0, 1'b1, 2'd1, 32'd4, 32'h404);
    watch_none(0, 6, seen);
    chk("t029_leq_blocked", seen, 1'b0);
    step(1);
    drive(1, 1'b1, 2'd2, 32'd0, 32'h0);
    wait_ready(1, n);
    chk("t029_deq_first", n, 1);
    step(1);
    drive(1, 1'b0, 2'd2, 32'd0, 32'h0);
    wait_ready(0, n);
    chk("t029_leq_after", n, 3);
    step(1);
    drive(0, 1'b0, 2'd1, 32'd4, 32'h404);
    step(3);
    chk("t029_count", bus.count, 2'd3);
    repeat (3) issue(1, 2'd2, 32'd0, 32'h0);
    step(3);

    // Both requesters hold LEQ until the heap is full. Record the order of winners.
    drive(0, 1'b1, 2'd1, 32'd20, 32'hC0);
    drive(1, 1'b1, 2'd1, 32'd21, 32'hC1);
    order = 3'b000;
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      n = 0;
      while (!seen && n < 30) begin
        @(negedge clk);
        n++;
        seen = bus.req0_ready | bus.req1_ready;
      end
      order[2-k] = bus.req1_ready;
      @(posedge clk);
    end
    #1;
    drive(0, 1'b0, 2'd1, 32'd20, 32'hC0);
    drive(1, 1'b0, 2'd1, 32'd21, 32'hC1);
    chk("t030_order", order, RR ? 3'b010 : 3'b000);
    repeat (3) issue(0, 2'd2, 32'd0, 32'h0);
    step(3);

    // An illegal op pulses err for one cycle and leaves root and count alone.
    issue(0, 2'd3, 32'd9, 32'hDEAD);
    @(negedge clk);
    chk("t031_err", bus.err_illegal, 1'b1);
    chk("t031_root_op", bus.root_op, 2'd0);
    chk("t031_count", bus.count, 2'd0);
    @(negedge clk);
    chk("t031_err_clear", bus.err_illegal, 1'b0);
    step(2);

    // root_ready gates new grants but does not disturb an op already issued.
    bus.root_ready = 1'b0;
    drive(0, 1'b1, 2'd1, 32'd11, 32'hBB);
    watch_none(0, 4, seen);
    chk("t022_blocked", seen, 1'b0);
    step(1);
    bus.root_ready = 1'b1;
    wait_ready(0, n);
    step(1);
    bus.root_ready = 1'b0;
    drive(0, 1'b0, 2'd1, 32'd11, 32'hBB);
    @(negedge clk);
    chk("t022_root_op", bus.root_op, 2'd1);
    chk("t022_root_pri", bus.root_pri, 32'd11);
    step(2);
    bus.root_ready = 1'b1;

    // Reset asserted mid-ISSUE clears count and root_op without waiting for a clock.
    issue(1, 2'd1, 32'd12, 32'hCC);
    chk("t032_count_pre", bus.count, 2'd2);
    drive(0, 1'b1, 2'd1, 32'd13, 32'hDD);
    rst = 1'b1;
    #1;
    chk("t032_root_op", bus.root_op, 2'd0);
    chk("t032_count", bus.count, 2'd0);
    chk("t032_ready0", bus.req0_ready, 1'b0);
    step(1);
    rst = 1'b0;
    drive(0, 1'b0, 2'd1, 32'd13, 32'hDD);
    step(2);

    // Mixed traffic on both ports, checked by the model.
    issue(1, 2'd1, 32'h1234, 32'hFEED);
    issue(0, 2'd1, 32'h55, 32'hBEEF);
    issue(1, 2'd2, 32'h0, 32'h0);
    step(4);
    chk("mix_count", bus.count, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
